// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and sizing constants for the four-lane round-robin arbiter.
package rr_mux4_arbiter_pkg;

  localparam int LANES  = 4;
  localparam int ID_W   = 2;
  localparam int HOLD_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_mux4_arbiter_pick.sv
// Rotating priority search: first eligible lane at or after 'start', wrapping 3->0.
module rr_pick
  import rr_mux4_arbiter_pkg::*;
(
  input  logic [LANES-1:0] req,
  input  logic [LANES-1:0] mask,
  input  logic [ID_W-1:0]  start,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  logic [LANES-1:0] eligible;
  logic [ID_W-1:0]  lane;

  assign eligible = req & ~mask;

  // Walk the offsets from farthest to nearest so the nearest eligible lane wins.
  always_comb begin
    found = 1'b0;
    idx   = start;
    lane  = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      lane = start + ID_W'(k);
      if (eligible[lane]) begin
        found = 1'b1;
        idx   = lane;
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter driving a registered 2-to-4 grant decode and a 4:1 data select.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [4*DW-1:0]   din,
  output logic [3:0]        gnt,
  output logic [1:0]        gnt_id,
  output logic              gnt_valid,
  output logic [DW-1:0]     dout,
  output logic              dout_valid
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state, state_next;
  logic [ID_W-1:0]   ptr, ptr_next, gnt_id_next;
  logic [LANES-1:0]  gnt_next, cur_mask, pick_mask;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [ID_W-1:0]   pick_start, pick_idx;
  logic              pick_found, others, release_grant;

  assign cur_mask      = LANES'(1) << gnt_id;
  assign others        = |(req & ~cur_mask);
  assign release_grant = (state == GRANT) &&
                         (!req[gnt_id] || ((hold_cnt == HOLD_LAST) && others));

  // While idle the search starts at the saved pointer; on handover it skips the current owner.
  assign pick_mask  = (state == GRANT) ? cur_mask : '0;
  assign pick_start = (state == GRANT) ? gnt_id + ID_W'(1) : ptr;

  rr_pick u_pick (
    .req   (req),
    .mask  (pick_mask),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next  = state;
    gnt_id_next = gnt_id;
    gnt_next    = gnt;
    ptr_next    = ptr;
    hold_next   = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next  = GRANT;
          gnt_id_next = pick_idx;
          gnt_next    = LANES'(1) << pick_idx;
          hold_next   = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          ptr_next = gnt_id + ID_W'(1);
          if (pick_found) begin
            gnt_id_next = pick_idx;
            gnt_next    = LANES'(1) << pick_idx;
            hold_next   = '0;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end else if (hold_cnt != HOLD_LAST) begin
          hold_next = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      gnt      <= gnt_next;
      gnt_id   <= gnt_id_next;
      ptr      <= ptr_next;
      hold_cnt <= hold_next;
    end
  end

  assign gnt_valid  = (state == GRANT);
  assign dout_valid = gnt_valid & req[gnt_id];
  assign dout       = dout_valid ? din[gnt_id*DW +: DW] : '0;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Scoreboard bench for rr_mux4_arbiter: directed phases plus randomized traffic against a lane-owner model.
module tb_rr_mux4_arbiter;

  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [4*DW-1:0] din;
  logic [3:0]    gnt;
  logic [1:0]    gnt_id;
  logic          gnt_valid;
  logic [DW-1:0] dout;
  logic          dout_valid;

  rr_mux4_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din        (din),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .gnt_valid  (gnt_valid),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  typedef struct {
    logic [3:0]    gnt;
    logic [1:0]    gnt_id;
    logic          gnt_valid;
    logic [DW-1:0] dout;
    logic          dout_valid;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   scoring = 0;

  // Reference: who owns the shared path, how long they've had it, where the search resumes.
  int m_owner, m_last, m_held, m_ptr;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start, input int excl);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_held  = 0;
    m_ptr   = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [4*DW-1:0] d);
    exp_t e;
    int   w;
    if (m_owner < 0) begin
      w = pick(r, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_held = 0;
      end
    end else begin
      bit others, rel;
      others = (r & ~(4'b1 << m_owner)) != 4'b0;
      rel    = !r[m_owner] || (m_held >= MAX_HOLD - 1 && others);
      if (rel) begin
        m_ptr = (m_owner + 1) % 4;
        w = pick(r, m_ptr, m_owner);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_held = 0;
        end else begin
          m_owner = -1;
        end
      end else if (m_held < MAX_HOLD - 1) begin
        m_held++;
      end
    end
    e.gnt        = (m_owner >= 0) ? (4'b1 << m_owner) : 4'b0;
    e.gnt_id     = 2'(m_last);
    e.gnt_valid  = (m_owner >= 0);
    e.dout_valid = e.gnt_valid && r[m_last];
    e.dout       = e.dout_valid ? d[m_last*DW +: DW] : '0;
    sb.push_back(e);
  endtask

  task automatic drive_and_push(input logic [3:0] r, input logic [4*DW-1:0] d);
    req = r;
    din = d;
    model_step(r, d);
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic [4*DW-1:0] d);
    @(negedge clk);
    drive_and_push(r, d);
    @(posedge clk);
  endtask

  // Monitor: compares each registered/combinational output set just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scoring && sb.size() > 0) begin
        e = sb.pop_front();
        check_output("sb_gnt", int'(gnt), int'(e.gnt));
        check_output("sb_gnt_id", int'(gnt_id), int'(e.gnt_id));
        check_output("sb_gnt_valid", int'(gnt_valid), int'(e.gnt_valid));
        check_output("sb_dout_valid", int'(dout_valid), int'(e.dout_valid));
        check_output("sb_dout", int'(dout), int'(e.dout));
      end
    end
  end

  initial begin
    logic [3:0] r;
    rst = 1;
    req = 4'b1111;
    din = $urandom;
    model_reset();

    // Held in reset with everybody requesting: nothing may be granted.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_output("rst_gnt", int'(gnt), 0);
      check_output("rst_gnt_valid", int'(gnt_valid), 0);
      check_output("rst_dout", int'(dout), 0);
      check_output("rst_dout_valid", int'(dout_valid), 0);
    end

    // Full contention straight out of reset: 0,1,2,3,0 with MAX_HOLD cycles each.
    @(negedge clk);
    rst = 0;
    scoring = 1;
    drive_and_push(4'b1111, $urandom);
    @(posedge clk);
    #2;
    check_output("fair_id", int'(gnt_id), 0);
    for (int k = 1; k < 20; k++) begin
      apply_stimulus(4'b1111, $urandom);
      #2;
      check_output("fair_id", int'(gnt_id), (k / MAX_HOLD) % 4);
      check_output("fair_valid", int'(gnt_valid), 1);
    end

    // Single requester on lane 2 with a known data byte.
    apply_stimulus(4'b0000, $urandom);
    apply_stimulus(4'b0000, $urandom);
    apply_stimulus(4'b0100, 32'h11A52233);
    #2;
    check_output("single_gnt", int'(gnt), 4'b0100);
    check_output("single_dout", int'(dout), 8'hA5);
    @(negedge clk);
    drive_and_push(4'b0000, 32'h11A52233);
    #1;
    check_output("drop_dout_valid", int'(dout_valid), 0);
    check_output("drop_gnt_still", int'(gnt), 4'b0100);
    @(posedge clk);
    #2;
    check_output("drop_gnt_next", int'(gnt), 0);

    // Early release: lane 1 drops while lane 3 waits.
    apply_stimulus(4'b0000, $urandom);
    apply_stimulus(4'b0010, $urandom);
    apply_stimulus(4'b1010, $urandom);
    apply_stimulus(4'b1010, $urandom);
    apply_stimulus(4'b1000, $urandom);
    #2;
    check_output("early_gnt", int'(gnt), 4'b1000);
    check_output("early_id", int'(gnt_id), 3);

    // Solo requester must never be released by expiry.
    for (int k = 0; k < 21; k++) begin
      apply_stimulus(4'b0001, $urandom);
      #2;
      check_output("solo_gnt", int'(gnt), 4'b0001);
    end

    // Asynchronous reset between edges while lane 1 holds the grant.
    apply_stimulus(4'b0010, $urandom);
    apply_stimulus(4'b0010, $urandom);
    #2;
    check_output("pre_rst_gnt", int'(gnt), 4'b0010);
    #1;
    scoring = 0;
    sb.delete();
    rst = 1;
    #1;
    check_output("async_gnt", int'(gnt), 0);
    check_output("async_valid", int'(gnt_valid), 0);
    check_output("async_dout_valid", int'(dout_valid), 0);
    req = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    scoring = 1;
    drive_and_push(4'b1111, $urandom);
    @(posedge clk);
    #2;
    check_output("post_rst_gnt", int'(gnt), 4'b0001);

    // Randomized traffic with persistent requests.
    r = 4'b1111;
    for (int k = 0; k < 400; k++) begin
      r = r ^ 4'($urandom & $urandom);
      apply_stimulus(r, $urandom);
    end

    @(posedge clk);
    #2;
    check_output("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
